// File: rtl/dld_display_pkg.sv
// Shared display-path types and helpers for the digit scan logic.
package dld_display_pkg;

  // Widest digit row any display block in this codebase drives.
  localparam int MAX_CH = 32;

  // All digit enables inactive (active-low).
  localparam logic [MAX_CH-1:0] AN_OFF = '1;

  typedef enum logic [1:0] {
    OFF,
    GUARD,
    DRIVE
  } scanState_t;

  // Active-low one-hot enable for digit idx; out-of-range idx gives all-off.
  // Callers size-cast the result down to their own channel count.
  function automatic logic [MAX_CH-1:0] onehot_n(input int unsigned idx,
                                                 input int unsigned channels);
    logic [MAX_CH-1:0] result;
    result = AN_OFF;
    if (idx < channels) begin
      result = ~(MAX_CH'(1) << idx);
    end
    return result;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running refresh prescaler with enable; pulses tick once per wrap.
module scan_prescaler #(
  parameter int DIV_BITS = 17
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  logic [DIV_BITS-1:0] count;

  // Count while enabled; tick follows the all-ones count by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (en) begin
      count <= count + 1'b1;
      tick  <= (count == '1);
    end else begin
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/scan_mux_n.sv
// Registered N-way digit selector with auto scan, manual select and blanking.
module scan_mux_n
  import dld_display_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 4,
  parameter int DIV_BITS = 17,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]       blank_mask,
  output logic [WIDTH-1:0]          y,
  output logic [SEL_W-1:0]          sel_out,
  output logic [CHANNELS-1:0]       an_n,
  output logic                      tick
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W:0]   CH_LIM   = (SEL_W + 1)'(CHANNELS);

  scanState_t          state, nextState;
  logic [SEL_W-1:0]    idx, nextIdx;
  logic [WIDTH-1:0]    yNext;
  logic [SEL_W-1:0]    selNext;
  logic [CHANNELS-1:0] anNext;
  logic                blankNext;

  scan_prescaler #(
    .DIV_BITS (DIV_BITS)
  ) uPrescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (tick)
  );

  // State, index and all outputs registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= OFF;
      idx     <= '0;
      y       <= '0;
      sel_out <= '0;
      an_n    <= CHANNELS'(AN_OFF);
    end else begin
      state   <= nextState;
      idx     <= nextIdx;
      y       <= yNext;
      sel_out <= selNext;
      an_n    <= anNext;
    end
  end

  // Next state/index, then the output values that state will present.
  // Outputs are derived from the next state so they line up with it.
  always_comb begin
    nextState = state;
    nextIdx   = idx;
    yNext     = y;
    selNext   = sel_out;
    anNext    = CHANNELS'(AN_OFF);
    blankNext = 1'b0;

    if (!en) begin
      nextState = OFF;
    end else begin
      unique case (state)
        OFF:   nextState = GUARD;
        GUARD: nextState = DRIVE;
        DRIVE: begin
          if (!mode) begin
            if (tick) begin
              nextIdx   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
              nextState = GUARD;
            end
          end else if ((sel_in != idx) && ({1'b0, sel_in} < CH_LIM)) begin
            nextIdx   = sel_in;
            nextState = GUARD;
          end
        end
        default: nextState = OFF;
      endcase
    end

    if (nextState != OFF) begin
      selNext   = nextIdx;
      blankNext = blank_mask[nextIdx];
      yNext     = blankNext ? '0 : data_in[int'(nextIdx)*WIDTH +: WIDTH];
      if ((nextState == DRIVE) && !blankNext) begin
        anNext = CHANNELS'(onehot_n(32'(nextIdx), CHANNELS));
      end
    end
  end

endmodule

// File: tb/tb_scan_mux_n.sv
// Randomised bench for scan_mux_n: 4-channel and 3-channel instances vs a reference model.
module tb_scan_mux_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        mode;
  logic [1:0]  selIn;
  logic [15:0] dataIn;
  logic [3:0]  blankMask;

  logic [3:0]  y4, an4;
  logic [1:0]  sel4;
  logic        tick4;
  logic [3:0]  y3;
  logic [2:0]  an3;
  logic [1:0]  sel3;
  logic        tick3;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  localparam int S_OFF = 0, S_GUARD = 1, S_DRIVE = 2;
  int chans [2] = '{4, 3};
  int divb  [2] = '{2, 1};
  int mCnt [2], mTick [2], mState [2], mIdx [2], mY [2], mSel [2], mAn [2];

  always #5 clk = ~clk;

  scan_mux_n #(.CHANNELS(4), .WIDTH(4), .DIV_BITS(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(selIn),
    .data_in(dataIn), .blank_mask(blankMask),
    .y(y4), .sel_out(sel4), .an_n(an4), .tick(tick4)
  );

  scan_mux_n #(.CHANNELS(3), .WIDTH(4), .DIV_BITS(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(selIn),
    .data_in(dataIn[11:0]), .blank_mask(blankMask[2:0]),
    .y(y3), .sel_out(sel3), .an_n(an3), .tick(tick3)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic void modelReset();
    for (int k = 0; k < 2; k++) begin
      mCnt[k] = 0; mTick[k] = 0; mState[k] = S_OFF; mIdx[k] = 0;
      mY[k] = 0; mSel[k] = 0; mAn[k] = (1 << chans[k]) - 1;
    end
  endfunction

  // One clock of the behavioural model, using the inputs held across the edge.
  function automatic void modelStep(input int k);
    int ns, ni, blank;
    ns = mState[k];
    ni = mIdx[k];
    if (!en) ns = S_OFF;
    else if (mState[k] == S_OFF) ns = S_GUARD;
    else if (mState[k] == S_GUARD) ns = S_DRIVE;
    else if (!mode) begin
      if (mTick[k] != 0) begin
        ni = (mIdx[k] + 1) % chans[k];
        ns = S_GUARD;
      end
    end else if ((int'(selIn) != mIdx[k]) && (int'(selIn) < chans[k])) begin
      ni = int'(selIn);
      ns = S_GUARD;
    end

    mTick[k] = (en && mCnt[k] == (1 << divb[k]) - 1) ? 1 : 0;
    if (en) mCnt[k] = (mCnt[k] + 1) % (1 << divb[k]);

    mState[k] = ns;
    mIdx[k] = ni;
    mAn[k] = (1 << chans[k]) - 1;
    if (ns != S_OFF) begin
      blank = (int'(blankMask) >> ni) & 1;
      mSel[k] = ni;
      mY[k] = blank ? 0 : ((int'(dataIn) >> (4 * ni)) & 15);
      if (ns == S_DRIVE && !blank) mAn[k] = mAn[k] & ~(1 << ni);
    end
  endfunction

  task automatic compareAll();
    checkVal("y4",    32'(y4),    32'(mY[0]));
    checkVal("sel4",  32'(sel4),  32'(mSel[0]));
    checkVal("an4",   32'(an4),   32'(mAn[0]));
    checkVal("tick4", 32'(tick4), 32'(mTick[0]));
    checkVal("y3",    32'(y3),    32'(mY[1]));
    checkVal("sel3",  32'(sel3),  32'(mSel[1]));
    checkVal("an3",   32'(an3),   32'(mAn[1]));
    checkVal("tick3", 32'(tick3), 32'(mTick[1]));
    checkVal("sel3Range", 32'(sel3 < 2'd3), 32'd1);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    if (!rst_n) modelReset();
    else begin
      modelStep(0);
      modelStep(1);
    end
    compareAll();
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic asyncReset();
    rst_n = 1'b0;
    #1;
    modelReset();
    compareAll();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; mode = 1'b0; selIn = '0;
    dataIn = 16'h4321; blankMask = '0;
    #2;
    asyncReset();

    // Auto scan from reset: GUARD then digit 0 driven.
    en = 1'b1;
    cycle();
    checkVal("guardAn", 32'(an4), 32'hF);
    checkVal("guardY",  32'(y4),  32'h1);
    cycle();
    checkVal("drive0An", 32'(an4), 32'hE);
    checkVal("drive0Y",  32'(y4),  32'h1);
    runCycles(20);

    // Manual select 2, then 0; ticks must not move the index.
    mode = 1'b1; selIn = 2'd2;
    runCycles(12);
    checkVal("man2An", 32'(an4), 32'hB);
    checkVal("man2Y",  32'(y4),  32'h3);
    selIn = 2'd0;
    runCycles(12);
    checkVal("man0An", 32'(an4), 32'hE);
    // Out-of-range manual select on the 3-channel instance.
    selIn = 2'd3;
    runCycles(8);

    // Blanking of channel 2 in auto mode.
    mode = 1'b0; blankMask = 4'b0100;
    runCycles(24);
    blankMask = '0;

    // Data change while driving, then disable and re-enable.
    runCycles(6);
    dataIn = 16'h4A21;
    runCycles(2);
    en = 1'b0;
    runCycles(5);
    en = 1'b1;
    runCycles(10);

    // Async reset mid-scan.
    runCycles(3);
    asyncReset();
    runCycles(10);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      selIn = 2'($urandom);
      if ($urandom_range(0, 7) == 0) dataIn = 16'($urandom);
      if ($urandom_range(0, 15) == 0) blankMask = 4'($urandom);
      if ($urandom_range(0, 199) == 0) asyncReset();
      else cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
